// File: rtl/common_pkg.sv
// Shared CLIC sizing, entry/index/priority types and the arbitration FSM encoding.
package common_pkg;
  localparam int NR_INDEX_BITS = 3;
  localparam int NR_PRIO_BITS  = 3;
  localparam int NR_ENTRIES    = 2**NR_INDEX_BITS;

  typedef logic                     Entry_t;
  typedef logic [NR_ENTRIES-1:0]    Entries_t;
  typedef logic [NR_INDEX_BITS-1:0] Index_t;
  typedef logic [NR_PRIO_BITS-1:0]  Prio_t;

  typedef enum logic [2:0] {IDLE, ARB, IDX, RESOLVE, OFFER} ClicState_t;
endpackage

// File: rtl/can_arb_step.sv
// One bit of wired-OR/lose arbitration: a contender presenting 0 drops out
// whenever any other contender presents 1 on the same bit.
module can_arb_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] contender,
  input  logic [N-1:0] bits,
  output logic [N-1:0] nxt
);
  logic or_v;

  assign or_v = |(contender & bits);
  assign nxt  = contender & ~({N{or_v}} & ~bits);
endmodule

// File: rtl/can_clic_ctrl.sv
// Bit-serial CLIC controller: pending/enable/prio state, MSB-first priority
// arbitration, level-gated valid/ready offer. Define CAN_CLIC_INDEX_ARB_EN to
// break ties with extra serial index-bit cycles instead of a priority encoder.
module can_clic_ctrl #(
  parameter  int NR_INDEX_BITS = common_pkg::NR_INDEX_BITS,
  parameter  int NR_PRIO_BITS  = common_pkg::NR_PRIO_BITS,
  localparam int N             = 2**NR_INDEX_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             irq_set_i,
  input  logic [NR_PRIO_BITS-1:0]  level_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [NR_INDEX_BITS-1:0] cfg_index_i,
  input  logic [NR_PRIO_BITS-1:0]  cfg_prio_i,
  input  logic                     cfg_enable_i,
  output logic                     irq_valid_o,
  input  logic                     irq_ready_i,
  output logic [NR_INDEX_BITS-1:0] irq_index_o,
  output logic [NR_PRIO_BITS-1:0]  irq_prio_o,
  output logic                     busy_o
);
  import common_pkg::*;

  localparam int PB_W = (NR_PRIO_BITS  > 1) ? $clog2(NR_PRIO_BITS)  : 1;
  localparam int IB_W = (NR_INDEX_BITS > 1) ? $clog2(NR_INDEX_BITS) : 1;

  ClicState_t                      state;
  logic [N-1:0]                    pending, enable, contender, contender_nxt;
  logic [N-1:0]                    col, clr_mask;
  logic [N-1:0][NR_PRIO_BITS-1:0]  prio;
  logic [NR_PRIO_BITS-1:0]         snap_level;
  logic [PB_W-1:0]                 pb;
  logic [NR_INDEX_BITS-1:0]        winner;
  logic                            cfg_we, claim;

  assign cfg_we = cfg_valid_i & cfg_ready_o;
  assign claim  = (state == OFFER) & irq_ready_i;

`ifdef CAN_CLIC_INDEX_ARB_EN
  logic [IB_W-1:0]                  ib;
  logic [N-1:0][NR_INDEX_BITS-1:0] idx_tab;

  for (genvar g = 0; g < N; g++) begin : g_idx
    assign idx_tab[g] = NR_INDEX_BITS'(g);
  end

  // Inverted index bits make the lowest index survive the or/lose rule.
  always_comb begin
    col = '0;
    for (int i = 0; i < N; i++)
      col[i] = (state == IDX) ? ~idx_tab[i][ib] : prio[i][pb];
  end

  // Exactly one contender is left, so a plain OR-encoder suffices.
  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++)
      if (contender[i]) winner = winner | NR_INDEX_BITS'(i);
  end
`else
  always_comb begin
    col = '0;
    for (int i = 0; i < N; i++) col[i] = prio[i][pb];
  end

  // Equal-priority survivors are resolved toward the lowest index.
  always_comb begin
    winner = '0;
    for (int i = N-1; i >= 0; i--)
      if (contender[i]) winner = NR_INDEX_BITS'(i);
  end
`endif

  can_arb_step #(.N(N)) u_step (
    .contender (contender),
    .bits      (col),
    .nxt       (contender_nxt)
  );

  always_comb begin
    clr_mask = '0;
    if (claim) clr_mask[irq_index_o] = 1'b1;
  end

  // A set arriving on the claim cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      enable  <= '0;
      prio    <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | irq_set_i;
      if (cfg_we) begin
        enable[cfg_index_i] <= cfg_enable_i;
        prio[cfg_index_i]   <= cfg_prio_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      contender   <= '0;
      snap_level  <= '0;
      pb          <= '0;
`ifdef CAN_CLIC_INDEX_ARB_EN
      ib          <= '0;
`endif
      irq_valid_o <= 1'b0;
      irq_index_o <= '0;
      irq_prio_o  <= '0;
      busy_o      <= 1'b0;
      cfg_ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|(pending & enable)) begin
            contender   <= pending & enable;
            snap_level  <= level_i;
            pb          <= PB_W'(NR_PRIO_BITS-1);
            state       <= ARB;
            busy_o      <= 1'b1;
            cfg_ready_o <= 1'b0;
          end else begin
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
          end
        end
        ARB: begin
          contender <= contender_nxt;
          pb        <= pb - PB_W'(1);
          if (pb == '0) begin
`ifdef CAN_CLIC_INDEX_ARB_EN
            ib    <= IB_W'(NR_INDEX_BITS-1);
            state <= IDX;
`else
            state <= RESOLVE;
`endif
          end
        end
`ifdef CAN_CLIC_INDEX_ARB_EN
        IDX: begin
          contender <= contender_nxt;
          ib        <= ib - IB_W'(1);
          if (ib == '0) state <= RESOLVE;
        end
`endif
        RESOLVE: begin
          if (prio[winner] > snap_level) begin
            irq_index_o <= winner;
            irq_prio_o  <= prio[winner];
            irq_valid_o <= 1'b1;
            state       <= OFFER;
          end else begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
          end
        end
        OFFER: begin
          if (irq_ready_i) begin
            irq_valid_o <= 1'b0;
            state       <= IDLE;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_contender: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESOLVE) |-> (contender != '0));
`ifdef CAN_CLIC_INDEX_ARB_EN
  a_one_winner: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESOLVE) |-> $onehot(contender));
`endif
endmodule
